// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and sizes for the store queue slice:
// queue geometry, store size encoding, entry layout and memory request layout.
package uarch_pkg;

    localparam int TAG_WIDTH     = 6;
    localparam int SQ_ENTRIES    = 8;
    localparam int CPU_ADDR_BITS = 32;
    localparam int CPU_DATA_BITS = 32;
    localparam int CPU_MASK_BITS = CPU_DATA_BITS / 8;
    localparam int SQ_IDX_W      = $clog2(SQ_ENTRIES);
    localparam int SQ_PTR_W      = SQ_IDX_W + 1;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } store_size_e;

    typedef struct packed {
        logic                     valid;
        logic                     done;
        logic                     committed;
        logic [TAG_WIDTH-1:0]     rob_tag;
        store_size_e              size;
        logic [CPU_ADDR_BITS-1:0] addr;
        logic [CPU_DATA_BITS-1:0] data;
    } sq_entry_t;

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] addr;
        logic [CPU_DATA_BITS-1:0] data;
        logic [CPU_MASK_BITS-1:0] wmask;
    } mem_store_req_t;

    // Number of set bits in a two-bit request vector.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/store_align.sv
// Places an unshifted store value into its byte lanes and builds the byte
// enables from the store size and the low address bits.
module store_align
    import uarch_pkg::*;
(
    input  logic [1:0]               size,
    input  logic [1:0]               offset,
    input  logic [CPU_DATA_BITS-1:0] data_in,
    output logic [CPU_DATA_BITS-1:0] data_out,
    output logic [CPU_MASK_BITS-1:0] wmask
);

    localparam logic [CPU_MASK_BITS-1:0] MASK_B = {{(CPU_MASK_BITS-1){1'b0}}, 1'b1};
    localparam logic [CPU_MASK_BITS-1:0] MASK_H = {{(CPU_MASK_BITS-2){1'b0}}, 2'b11};
    localparam logic [CPU_MASK_BITS-1:0] MASK_W = {CPU_MASK_BITS{1'b1}};

    // Replicate the value across lanes; the mask alone selects the written bytes.
    always_comb begin
        data_out = {CPU_DATA_BITS{1'b0}};
        wmask    = {CPU_MASK_BITS{1'b0}};
        case (size)
            SIZE_B: begin
                data_out = {CPU_MASK_BITS{data_in[7:0]}};
                wmask    = MASK_B << offset;
            end
            SIZE_H: begin
                data_out = {(CPU_MASK_BITS/2){data_in[15:0]}};
                wmask    = MASK_H << offset;
            end
            SIZE_W: begin
                data_out = data_in;
                wmask    = MASK_W;
            end
            default: begin
                data_out = {CPU_DATA_BITS{1'b0}};
                wmask    = {CPU_MASK_BITS{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/store_queue_chk.sv
// Protocol checks for the store queue: allocation only with room, at most
// one execute match, and commits that arrive in order on executed entries.
module store_queue_chk
    import uarch_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    input logic [1:0]            alloc_we,
    input logic [1:0]            sq_rdy,
    input logic [SQ_ENTRIES-1:0] exec_match,
    input logic                  commit_val0,
    input logic                  commit_val1,
    input logic [TAG_WIDTH-1:0]  commit_id0,
    input logic [TAG_WIDTH-1:0]  commit_id1,
    input logic                  cmt0_valid,
    input logic                  cmt0_done,
    input logic [TAG_WIDTH-1:0]  cmt0_tag,
    input logic                  cmt1_valid,
    input logic                  cmt1_done,
    input logic [TAG_WIDTH-1:0]  cmt1_tag
);

    logic [TAG_WIDTH-1:0] first_id_s;

    // The first asserted commit port always names the oldest uncommitted entry.
    always_comb begin
        if (commit_val0) begin
            first_id_s = commit_id0;
        end else begin
            first_id_s = commit_id1;
        end
    end

    a_alloc_two: assert property (@(posedge clk) disable iff (rst)
        (alloc_we == 2'b11) |-> sq_rdy[1])
        else $error("store_queue: dual allocate without two free slots");

    a_alloc_one: assert property (@(posedge clk) disable iff (rst)
        (alloc_we != 2'b00) |-> sq_rdy[0])
        else $error("store_queue: allocate into a full queue");

    a_exec_unique: assert property (@(posedge clk) disable iff (rst)
        $onehot0(exec_match))
        else $error("store_queue: execute tag matched several entries");

    a_commit_first: assert property (@(posedge clk) disable iff (rst)
        (commit_val0 || commit_val1) |-> (cmt0_valid && cmt0_done && (cmt0_tag == first_id_s)))
        else $error("store_queue: first commit does not match oldest executed entry");

    a_commit_second: assert property (@(posedge clk) disable iff (rst)
        (commit_val0 && commit_val1) |-> (cmt1_valid && cmt1_done && (cmt1_tag == commit_id1)))
        else $error("store_queue: second commit does not match next executed entry");

endmodule

// File: rtl/store_queue.sv
// In-order store queue: dispatch allocates at tail, the store unit fills
// entries by ROB tag, the ROB commits at cmt, and committed entries drain
// from head to memory. Flush trims tail back to the commit point.
module store_queue
    import uarch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    output logic [1:0]               sq_rdy,
    input  logic [1:0]               alloc_we,
    input  logic [TAG_WIDTH-1:0]     alloc_rob_tag0,
    input  logic [TAG_WIDTH-1:0]     alloc_rob_tag1,
    input  logic [1:0]               alloc_size0,
    input  logic [1:0]               alloc_size1,
    input  logic                     exec_val,
    input  logic [TAG_WIDTH-1:0]     exec_rob_tag,
    input  logic [CPU_ADDR_BITS-1:0] exec_addr,
    input  logic [CPU_DATA_BITS-1:0] exec_data,
    input  logic                     commit_store_val0,
    input  logic                     commit_store_val1,
    input  logic [TAG_WIDTH-1:0]     commit_store_id0,
    input  logic [TAG_WIDTH-1:0]     commit_store_id1,
    output logic                     mem_req_val,
    input  logic                     mem_req_rdy,
    output logic [CPU_ADDR_BITS-1:0] mem_req_addr,
    output logic [CPU_DATA_BITS-1:0] mem_req_data,
    output logic [CPU_MASK_BITS-1:0] mem_req_wmask,
    output logic                     sq_empty
);

    localparam logic [SQ_IDX_W-1:0] IDX_ONE = {{(SQ_IDX_W-1){1'b0}}, 1'b1};

    sq_entry_t ent_r   [SQ_ENTRIES];
    sq_entry_t ent_n_s [SQ_ENTRIES];

    logic [SQ_PTR_W-1:0] head_r, cmt_r, tail_r;
    logic [SQ_PTR_W-1:0] head_n_s, cmt_n_s, tail_n_s, count_s;
    logic [SQ_IDX_W-1:0] head_idx_s, cmt_idx0_s, cmt_idx1_s, tail_idx0_s, slot1_idx_s;
    logic [1:0]          n_cmt_s, n_alloc_s;
    logic [SQ_ENTRIES-1:0] match_s, commit_mask_s, alloc0_hit_s, alloc1_hit_s, clear_s;
    logic                drain_s, mem_val_s;

    sq_entry_t           head_ent_s;
    mem_store_req_t      head_req_s;
    logic [CPU_DATA_BITS-1:0] align_data_s;
    logic [CPU_MASK_BITS-1:0] align_mask_s;

    assign count_s     = tail_r - head_r;
    assign head_idx_s  = head_r[SQ_IDX_W-1:0];
    assign cmt_idx0_s  = cmt_r[SQ_IDX_W-1:0];
    assign cmt_idx1_s  = cmt_idx0_s + IDX_ONE;
    assign tail_idx0_s = tail_r[SQ_IDX_W-1:0];
    assign slot1_idx_s = alloc_we[0] ? (tail_idx0_s + IDX_ONE) : tail_idx0_s;
    assign n_cmt_s     = popcount2({commit_store_val1, commit_store_val0});
    assign n_alloc_s   = popcount2(alloc_we);

    assign head_ent_s  = ent_r[head_idx_s];
    assign mem_val_s   = !rst && head_ent_s.valid && head_ent_s.committed;
    assign drain_s     = mem_val_s && mem_req_rdy;

    // Pointer updates; flush rewinds tail to the post-commit point and drops allocations.
    always_comb begin
        head_n_s = head_r + SQ_PTR_W'(drain_s);
        cmt_n_s  = cmt_r + SQ_PTR_W'(n_cmt_s);
        tail_n_s = flush ? cmt_n_s : (tail_r + SQ_PTR_W'(n_alloc_s));
    end

    // Per-entry decode: execute CAM, commit marks, allocation targets and clears.
    always_comb begin
        for (int i = 0; i < SQ_ENTRIES; i++) begin
            match_s[i]       = exec_val && ent_r[i].valid && !ent_r[i].committed
                               && (ent_r[i].rob_tag == exec_rob_tag);
            commit_mask_s[i] = ((n_cmt_s != 2'd0) && (cmt_idx0_s == SQ_IDX_W'(i)))
                            || ((n_cmt_s == 2'd2) && (cmt_idx1_s == SQ_IDX_W'(i)));
            alloc0_hit_s[i]  = !flush && alloc_we[0] && (tail_idx0_s == SQ_IDX_W'(i));
            alloc1_hit_s[i]  = !flush && alloc_we[1] && (slot1_idx_s == SQ_IDX_W'(i));
            clear_s[i]       = (drain_s && (head_idx_s == SQ_IDX_W'(i)))
                            || (flush && !(ent_r[i].committed || commit_mask_s[i]));
        end
    end

    // Next entry contents: clear beats allocation, which beats in-place updates.
    always_comb begin
        for (int i = 0; i < SQ_ENTRIES; i++) begin
            ent_n_s[i] = ent_r[i];
            if (clear_s[i]) begin
                ent_n_s[i] = '0;
            end else if (alloc0_hit_s[i]) begin
                ent_n_s[i]         = '0;
                ent_n_s[i].valid   = 1'b1;
                ent_n_s[i].rob_tag = alloc_rob_tag0;
                ent_n_s[i].size    = store_size_e'(alloc_size0);
            end else if (alloc1_hit_s[i]) begin
                ent_n_s[i]         = '0;
                ent_n_s[i].valid   = 1'b1;
                ent_n_s[i].rob_tag = alloc_rob_tag1;
                ent_n_s[i].size    = store_size_e'(alloc_size1);
            end else begin
                ent_n_s[i].done      = ent_r[i].done | match_s[i];
                ent_n_s[i].addr      = match_s[i] ? exec_addr : ent_r[i].addr;
                ent_n_s[i].data      = match_s[i] ? exec_data : ent_r[i].data;
                ent_n_s[i].committed = ent_r[i].committed | commit_mask_s[i];
            end
        end
    end

    // State registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= {SQ_PTR_W{1'b0}};
            cmt_r  <= {SQ_PTR_W{1'b0}};
            tail_r <= {SQ_PTR_W{1'b0}};
            for (int i = 0; i < SQ_ENTRIES; i++) begin
                ent_r[i] <= '0;
            end
        end else begin
            head_r <= head_n_s;
            cmt_r  <= cmt_n_s;
            tail_r <= tail_n_s;
            for (int i = 0; i < SQ_ENTRIES; i++) begin
                ent_r[i] <= ent_n_s[i];
            end
        end
    end

    store_align u_align (
        .size     (head_ent_s.size),
        .offset   (head_ent_s.addr[1:0]),
        .data_in  (head_ent_s.data),
        .data_out (align_data_s),
        .wmask    (align_mask_s)
    );

    // Memory request built from head registers, forced to zero when idle.
    always_comb begin
        head_req_s.addr  = {head_ent_s.addr[CPU_ADDR_BITS-1:2], 2'b00};
        head_req_s.data  = align_data_s;
        head_req_s.wmask = align_mask_s;
        if (mem_val_s) begin
            mem_req_addr  = head_req_s.addr;
            mem_req_data  = head_req_s.data;
            mem_req_wmask = head_req_s.wmask;
        end else begin
            mem_req_addr  = {CPU_ADDR_BITS{1'b0}};
            mem_req_data  = {CPU_DATA_BITS{1'b0}};
            mem_req_wmask = {CPU_MASK_BITS{1'b0}};
        end
    end

    // Occupancy flags; ready compares the pre-drain count so a full queue never reuses the draining slot.
    always_comb begin
        mem_req_val = mem_val_s;
        if (rst) begin
            sq_rdy   = 2'b11;
            sq_empty = 1'b1;
        end else begin
            sq_rdy   = {(count_s <= SQ_PTR_W'(SQ_ENTRIES - 2)), (count_s <= SQ_PTR_W'(SQ_ENTRIES - 1))};
            sq_empty = (count_s == {SQ_PTR_W{1'b0}});
        end
    end

    store_queue_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .alloc_we    (alloc_we),
        .sq_rdy      (sq_rdy),
        .exec_match  (match_s),
        .commit_val0 (commit_store_val0),
        .commit_val1 (commit_store_val1),
        .commit_id0  (commit_store_id0),
        .commit_id1  (commit_store_id1),
        .cmt0_valid  (ent_r[cmt_idx0_s].valid),
        .cmt0_done   (ent_r[cmt_idx0_s].done),
        .cmt0_tag    (ent_r[cmt_idx0_s].rob_tag),
        .cmt1_valid  (ent_r[cmt_idx1_s].valid),
        .cmt1_done   (ent_r[cmt_idx1_s].done),
        .cmt1_tag    (ent_r[cmt_idx1_s].rob_tag)
    );

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed scenarios plus a randomized
// wrap-around run, all checked against a queue-based program-order model.
module tb_store_queue;
    import uarch_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst, flush;
    logic [1:0]               sq_rdy;
    logic [1:0]               alloc_we;
    logic [TAG_WIDTH-1:0]     alloc_rob_tag0, alloc_rob_tag1;
    logic [1:0]               alloc_size0, alloc_size1;
    logic                     exec_val;
    logic [TAG_WIDTH-1:0]     exec_rob_tag;
    logic [31:0]              exec_addr, exec_data;
    logic                     commit_store_val0, commit_store_val1;
    logic [TAG_WIDTH-1:0]     commit_store_id0, commit_store_id1;
    logic                     mem_req_val, mem_req_rdy;
    logic [31:0]              mem_req_addr, mem_req_data;
    logic [3:0]               mem_req_wmask;
    logic                     sq_empty;

    always #5 clk = ~clk;

    store_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .sq_rdy(sq_rdy),
        .alloc_we(alloc_we), .alloc_rob_tag0(alloc_rob_tag0), .alloc_rob_tag1(alloc_rob_tag1),
        .alloc_size0(alloc_size0), .alloc_size1(alloc_size1),
        .exec_val(exec_val), .exec_rob_tag(exec_rob_tag), .exec_addr(exec_addr), .exec_data(exec_data),
        .commit_store_val0(commit_store_val0), .commit_store_val1(commit_store_val1),
        .commit_store_id0(commit_store_id0), .commit_store_id1(commit_store_id1),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_wmask(mem_req_wmask), .sq_empty(sq_empty)
    );

    // Reference model: live stores oldest first; ncmt = how many at the front are committed.
    typedef struct {
        logic [TAG_WIDTH-1:0] tag;
        logic [1:0]           size;
        bit                   done;
        bit                   cmtd;
        logic [31:0]          addr;
        logic [31:0]          data;
    } m_ent_t;

    m_ent_t mq[$];
    int     ncmt  = 0;
    int     total = 0;
    int     bad   = 0;

    function automatic logic [1:0] m_rdy();
        int free = SQ_ENTRIES - mq.size();
        return {(free >= 2), (free >= 1)};
    endfunction

    function automatic bit m_val();
        return (mq.size() > 0) && mq[0].cmtd;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a[1:0]);
        if (sz == 2'd0) return 4'(1 << off);
        else if (sz == 2'd1) return 4'(3 << off);
        else return 4'hF;
    endfunction

    function automatic logic [31:0] exp_data(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
        else if (sz == 2'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
        else return d;
    endfunction

    task automatic clear_inputs();
        flush = 1'b0; alloc_we = 2'b00; alloc_rob_tag0 = '0; alloc_rob_tag1 = '0;
        alloc_size0 = 2'd0; alloc_size1 = 2'd0; exec_val = 1'b0; exec_rob_tag = '0;
        exec_addr = 32'h0; exec_data = 32'h0; commit_store_val0 = 1'b0; commit_store_val1 = 1'b0;
        commit_store_id0 = '0; commit_store_id1 = '0; mem_req_rdy = 1'b0;
    endtask

    // Advance one clock and apply the cycle's inputs to the model.
    task automatic tick();
        bit drain;
        int nc;
        drain = m_val() && (mem_req_rdy === 1'b1);
        nc = int'(commit_store_val0) + int'(commit_store_val1);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            ncmt = 0;
        end else begin
            if (exec_val) begin
                foreach (mq[i]) begin
                    if (!mq[i].cmtd && mq[i].tag == exec_rob_tag) begin
                        mq[i].done = 1'b1; mq[i].addr = exec_addr; mq[i].data = exec_data;
                    end
                end
            end
            for (int k = 0; k < nc; k++) begin
                if (ncmt < mq.size()) begin mq[ncmt].cmtd = 1'b1; ncmt++; end
            end
            if (drain) begin void'(mq.pop_front()); ncmt--; end
            if (flush) begin
                while (mq.size() > ncmt) void'(mq.pop_back());
            end else begin
                if (alloc_we[0]) mq.push_back('{tag: alloc_rob_tag0, size: alloc_size0, done: 1'b0, cmtd: 1'b0, addr: 32'h0, data: 32'h0});
                if (alloc_we[1]) mq.push_back('{tag: alloc_rob_tag1, size: alloc_size1, done: 1'b0, cmtd: 1'b0, addr: 32'h0, data: 32'h0});
            end
        end
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1; tick();
        rst = 1'b0;
    endtask

    task automatic do_alloc1(input logic [TAG_WIDTH-1:0] t, input logic [1:0] sz);
        alloc_we = 2'b01; alloc_rob_tag0 = t; alloc_size0 = sz; tick();
    endtask

    task automatic do_exec(input logic [TAG_WIDTH-1:0] t, input logic [31:0] a, input logic [31:0] d);
        exec_val = 1'b1; exec_rob_tag = t; exec_addr = a; exec_data = d; tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; tick();
        total++; if (sq_rdy !== 2'b11) begin bad++; $display("FAIL rst_rdy: got %b want 11", sq_rdy); end
        total++; if (sq_empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", sq_empty); end
        total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL rst_val: got %b want 0", mem_req_val); end
        rst = 1'b0; tick();
        total++; if (sq_rdy !== 2'b11) begin bad++; $display("FAIL post_rst_rdy: got %b want 11", sq_rdy); end
        total++; if (sq_empty !== 1'b1) begin bad++; $display("FAIL post_rst_empty: got %b want 1", sq_empty); end
        total++; if ({mem_req_val, mem_req_addr, mem_req_data, mem_req_wmask} !== 69'h0)
            begin bad++; $display("FAIL post_rst_req: got val=%b a=%h d=%h m=%b want all 0", mem_req_val, mem_req_addr, mem_req_data, mem_req_wmask); end
    endtask

    task automatic test_fill_full();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            alloc_we = 2'b11; alloc_rob_tag0 = TAG_WIDTH'(8 + 2*p); alloc_rob_tag1 = TAG_WIDTH'(9 + 2*p);
            alloc_size0 = 2'd2; alloc_size1 = 2'd2; tick();
        end
        total++; if (sq_rdy !== 2'b00 || sq_rdy !== m_rdy()) begin bad++; $display("FAIL full_rdy: got %b want 00", sq_rdy); end
        total++; if (sq_empty !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", sq_empty); end
        do_exec(6'd8, 32'h0000_0100, 32'hCAFE_F00D);
        commit_store_val0 = 1'b1; commit_store_id0 = 6'd8; tick();
        total++; if (mem_req_val !== 1'b1 || sq_rdy !== 2'b00)
            begin bad++; $display("FAIL full_head_val: got val=%b rdy=%b want 1/00", mem_req_val, sq_rdy); end
        mem_req_rdy = 1'b1; tick();
        total++; if (sq_rdy !== 2'b01 || sq_rdy !== m_rdy()) begin bad++; $display("FAIL one_drain_rdy: got %b want 01", sq_rdy); end
    endtask

    task automatic test_byte_store();
        do_reset();
        do_alloc1(6'd5, 2'd0);
        do_exec(6'd5, 32'h0000_1003, 32'h0000_00AB);
        commit_store_val0 = 1'b1; commit_store_id0 = 6'd5;
        total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL byte_early_val: got %b want 0", mem_req_val); end
        tick();
        total++; if ({mem_req_val, mem_req_addr, mem_req_wmask, mem_req_data} !== {1'b1, 32'h1000, 4'b1000, 32'hABAB_ABAB})
            begin bad++; $display("FAIL byte_req: got val=%b a=%h m=%b d=%h want 1 00001000 1000 abababab", mem_req_val, mem_req_addr, mem_req_wmask, mem_req_data); end
        for (int k = 0; k < 3; k++) begin
            mem_req_rdy = 1'b0; tick();
            total++; if ({mem_req_val, mem_req_addr, mem_req_wmask, mem_req_data} !== {1'b1, 32'h1000, 4'b1000, 32'hABAB_ABAB})
                begin bad++; $display("FAIL byte_hold%0d: got val=%b a=%h m=%b d=%h", k, mem_req_val, mem_req_addr, mem_req_wmask, mem_req_data); end
        end
        mem_req_rdy = 1'b1; tick();
        total++; if (sq_empty !== 1'b1 || mem_req_val !== 1'b0)
            begin bad++; $display("FAIL byte_drained: got empty=%b val=%b want 1/0", sq_empty, mem_req_val); end
    endtask

    task automatic test_flush_mixed();
        do_reset();
        alloc_we = 2'b11; alloc_rob_tag0 = 6'd1; alloc_rob_tag1 = 6'd2; alloc_size0 = 2'd2; alloc_size1 = 2'd1; tick();
        do_alloc1(6'd3, 2'd0);
        do_exec(6'd1, 32'h0000_2000, 32'h1122_3344);
        do_exec(6'd2, 32'h0000_2002, 32'h0000_5566);
        flush = 1'b1; commit_store_val0 = 1'b1; commit_store_id0 = 6'd1; tick();
        total++; if ({mem_req_val, mem_req_addr, mem_req_wmask, mem_req_data} !== {1'b1, 32'h2000, 4'hF, 32'h1122_3344})
            begin bad++; $display("FAIL flush_head: got val=%b a=%h m=%b d=%h", mem_req_val, mem_req_addr, mem_req_wmask, mem_req_data); end
        total++; if (sq_rdy !== m_rdy() || sq_rdy !== 2'b11) begin bad++; $display("FAIL flush_rdy: got %b want 11", sq_rdy); end
        do_exec(6'd3, 32'h0000_3001, 32'h0000_0077);
        total++; if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h2000)
            begin bad++; $display("FAIL flush_stale_exec: got val=%b a=%h want 1/00002000", mem_req_val, mem_req_addr); end
        mem_req_rdy = 1'b1; tick();
        tick();
        total++; if (sq_empty !== 1'b1 || mem_req_val !== 1'b0)
            begin bad++; $display("FAIL flush_empty: got empty=%b val=%b want 1/0", sq_empty, mem_req_val); end
    endtask

    task automatic test_wrap_random();
        logic [1:0]  st_size [20];
        logic [31:0] st_addr [20];
        logic [31:0] st_data [20];
        int n_alloc = 0;
        int n_obs   = 0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            st_size[k] = 2'($urandom_range(0, 2));
            st_addr[k] = $urandom();
            if (st_size[k] == 2'd1) st_addr[k] = st_addr[k] & 32'hFFFF_FFFE;
            if (st_size[k] == 2'd2) st_addr[k] = st_addr[k] & 32'hFFFF_FFFC;
            st_data[k] = $urandom();
        end
        for (int cyc = 0; cyc < 3000 && n_obs < 20; cyc++) begin
            int   nmax, na, c, nc, j;
            int   nd[$];
            total++; if (mem_req_val !== m_val()) begin bad++; $display("FAIL wrap_val c%0d: got %b want %b", cyc, mem_req_val, m_val()); end
            total++; if (sq_rdy !== m_rdy()) begin bad++; $display("FAIL wrap_rdy c%0d: got %b want %b", cyc, sq_rdy, m_rdy()); end
            if (m_val()) begin
                total++;
                if ({mem_req_addr, mem_req_wmask, mem_req_data} !== {exp_addr(mq[0].addr), exp_mask(mq[0].size, mq[0].addr), exp_data(mq[0].size, mq[0].data)})
                    begin bad++; $display("FAIL wrap_req c%0d: got a=%h m=%b d=%h tag=%0d", cyc, mem_req_addr, mem_req_wmask, mem_req_data, mq[0].tag); end
            end
            mem_req_rdy = 1'($urandom_range(0, 1));
            if (mem_req_val === 1'b1 && mem_req_rdy) begin
                total++;
                if (n_obs >= 20 || mem_req_addr !== exp_addr(st_addr[n_obs]))
                    begin bad++; $display("FAIL wrap_order n%0d: got a=%h", n_obs, mem_req_addr); end
                n_obs++;
            end
            nmax = SQ_ENTRIES - mq.size();
            if (nmax > 2) nmax = 2;
            if (nmax > 20 - n_alloc) nmax = 20 - n_alloc;
            na = $urandom_range(0, nmax);
            if (na == 2) begin
                alloc_we = 2'b11;
                alloc_rob_tag0 = TAG_WIDTH'(32 + n_alloc); alloc_size0 = st_size[n_alloc];
                alloc_rob_tag1 = TAG_WIDTH'(33 + n_alloc); alloc_size1 = st_size[n_alloc + 1];
            end else if (na == 1) begin
                if ($urandom_range(0, 1) == 0) begin
                    alloc_we = 2'b01; alloc_rob_tag0 = TAG_WIDTH'(32 + n_alloc); alloc_size0 = st_size[n_alloc];
                end else begin
                    alloc_we = 2'b10; alloc_rob_tag1 = TAG_WIDTH'(32 + n_alloc); alloc_size1 = st_size[n_alloc];
                end
            end
            n_alloc += na;
            foreach (mq[i]) if (!mq[i].done) nd.push_back(i);
            if (nd.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = nd[$urandom_range(0, nd.size() - 1)];
                exec_val = 1'b1; exec_rob_tag = mq[j].tag;
                exec_addr = st_addr[int'(mq[j].tag) - 32]; exec_data = st_data[int'(mq[j].tag) - 32];
            end
            c = 0;
            while (c < 2 && ncmt + c < mq.size() && mq[ncmt + c].done) c++;
            nc = $urandom_range(0, c);
            if (nc == 2) begin
                commit_store_val0 = 1'b1; commit_store_id0 = mq[ncmt].tag;
                commit_store_val1 = 1'b1; commit_store_id1 = mq[ncmt + 1].tag;
            end else if (nc == 1) begin
                if ($urandom_range(0, 1) == 0) begin commit_store_val0 = 1'b1; commit_store_id0 = mq[ncmt].tag; end
                else begin commit_store_val1 = 1'b1; commit_store_id1 = mq[ncmt].tag; end
            end
            tick();
        end
        total++; if (n_obs != 20) begin bad++; $display("FAIL wrap_timeout: got %0d drains want 20", n_obs); end
    endtask

    task automatic test_dual_commit_drain();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            alloc_we = 2'b11; alloc_rob_tag0 = TAG_WIDTH'(20 + 2*p); alloc_rob_tag1 = TAG_WIDTH'(21 + 2*p);
            alloc_size0 = 2'd2; alloc_size1 = 2'd2; tick();
        end
        do_alloc1(6'd26, 2'd2);
        for (int k = 0; k < 3; k++) do_exec(TAG_WIDTH'(20 + k), 32'h400 + 32'(4*k), 32'hD0 + 32'(k));
        commit_store_val0 = 1'b1; commit_store_id0 = 6'd20; tick();
        total++; if (mem_req_val !== 1'b1 || sq_rdy !== 2'b01) begin bad++; $display("FAIL dual_pre: got val=%b rdy=%b want 1/01", mem_req_val, sq_rdy); end
        mem_req_rdy = 1'b1;
        commit_store_val0 = 1'b1; commit_store_id0 = 6'd21; commit_store_val1 = 1'b1; commit_store_id1 = 6'd22;
        alloc_we = 2'b01; alloc_rob_tag0 = 6'd27; alloc_size0 = 2'd2;
        tick();
        total++; if (sq_rdy !== 2'b01 || sq_rdy !== m_rdy()) begin bad++; $display("FAIL dual_count: got rdy=%b want 01", sq_rdy); end
        total++; if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h404 || mem_req_data !== 32'hD1)
            begin bad++; $display("FAIL dual_first: got val=%b a=%h d=%h want 1/404/d1", mem_req_val, mem_req_addr, mem_req_data); end
        mem_req_rdy = 1'b1; tick();
        total++; if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h408 || mem_req_data !== 32'hD2)
            begin bad++; $display("FAIL dual_second: got val=%b a=%h d=%h want 1/408/d2", mem_req_val, mem_req_addr, mem_req_data); end
        mem_req_rdy = 1'b1; tick();
        total++; if (mem_req_val !== 1'b0 || sq_rdy !== m_rdy()) begin bad++; $display("FAIL dual_after: got val=%b rdy=%b", mem_req_val, sq_rdy); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        do_alloc1(6'd40, 2'd2);
        do_exec(6'd40, 32'h0000_5000, 32'h1234_5678);
        commit_store_val0 = 1'b1; commit_store_id0 = 6'd40; tick();
        total++; if (mem_req_val !== 1'b1) begin bad++; $display("FAIL rmd_val: got %b want 1", mem_req_val); end
        rst = 1'b1; tick();
        total++; if (mem_req_val !== 1'b0 || sq_empty !== 1'b1 || sq_rdy !== 2'b11)
            begin bad++; $display("FAIL rmd_in_rst: got val=%b empty=%b rdy=%b want 0/1/11", mem_req_val, sq_empty, sq_rdy); end
        rst = 1'b0; tick();
        total++; if (mem_req_val !== 1'b0 || sq_empty !== 1'b1)
            begin bad++; $display("FAIL rmd_after: got val=%b empty=%b want 0/1", mem_req_val, sq_empty); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fill_full();
        test_byte_store();
        test_flush_mixed();
        test_wrap_random();
        test_dual_commit_drain();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
